// File: rtl/temperature_anomaly_filter.sv
// Temperature anomaly filter: deserializes samples from a two-wire serial
// stream and accepts or rejects each one against a tolerance band. The band
// is derived from the average of the recently accepted samples.
module temperature_anomaly_filter #(
  parameter int WIDTH       = 16,
  parameter int DEPTH_LOG2  = 4,
  parameter int TOL_SHIFT   = 3,
  parameter int MAX_REJECTS = 4,
  parameter int TIMEOUT     = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sda,
  input  logic             scl,
  output logic             temperatureReady,
  output logic [WIDTH-1:0] temperature,
  output logic             anomaly,
  output logic [7:0]       rejectStreak,
  output logic [1:0]       filterState
);

  localparam int DEPTH  = 1 << DEPTH_LOG2;
  localparam int SUM_W  = WIDTH + DEPTH_LOG2;
  localparam int BIT_W  = $clog2(WIDTH + 1);
  localparam int IDLE_W = $clog2(TIMEOUT + 1);
  localparam int FILL_W = DEPTH_LOG2 + 1;

  typedef enum logic [1:0] {FILL = 2'd0, TRACK = 2'd1} state_e;

  state_e                state_r, stateNext_s;
  logic [1:0]            sclSync_r, sdaSync_r;
  logic                  sclDelay_r, sclRise_s;
  logic [WIDTH-1:0]      shiftReg_r;
  logic [BIT_W-1:0]      bitCount_r;
  logic [IDLE_W-1:0]     idleCount_r;
  logic                  sampleValid_r;
  logic [WIDTH-1:0]      history_r [DEPTH];
  logic [DEPTH_LOG2-1:0] wrPtr_r, wrIdx_s;
  logic [FILL_W-1:0]     fillCount_r, fillInc_s;
  logic [SUM_W-1:0]      sum_r;
  logic [WIDTH-1:0]      upperBound_r, lowerBound_r;
  logic [WIDTH-1:0]      avg_s, tol_s, upperNext_s, lowerNext_s, oldEntry_s;
  logic [WIDTH:0]        upperSum_s;
  logic [7:0]            streakInc_s;
  logic                  inBounds_s, accept_s, reject_s, rebaseline_s;
  logic                  temperatureReady_r, anomaly_r;
  logic [WIDTH-1:0]      temperature_r;
  logic [7:0]            rejectStreak_r;

  assign sclRise_s = sclSync_r[1] & ~sclDelay_r;

  // Bring the asynchronous serial pins into the clk domain and delay scl for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclSync_r  <= 2'b00;
      sdaSync_r  <= 2'b00;
      sclDelay_r <= 1'b0;
    end else begin
      sclSync_r  <= {sclSync_r[0], scl};
      sdaSync_r  <= {sdaSync_r[0], sda};
      sclDelay_r <= sclSync_r[1];
    end
  end

  // Shift in bits MSB first, flag a complete frame, and drop a stalled partial frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shiftReg_r    <= '0;
      bitCount_r    <= '0;
      idleCount_r   <= '0;
      sampleValid_r <= 1'b0;
    end else begin
      sampleValid_r <= 1'b0;
      if (sclRise_s) begin
        shiftReg_r  <= {shiftReg_r[WIDTH-2:0], sdaSync_r[1]};
        idleCount_r <= '0;
        if (bitCount_r == BIT_W'(WIDTH - 1)) begin
          bitCount_r    <= '0;
          sampleValid_r <= 1'b1;
        end else begin
          bitCount_r <= bitCount_r + BIT_W'(1);
        end
      end else if (bitCount_r != '0) begin
        if (idleCount_r == IDLE_W'(TIMEOUT - 1)) begin
          bitCount_r  <= '0;
          idleCount_r <= '0;
          shiftReg_r  <= '0;
        end else begin
          idleCount_r <= idleCount_r + IDLE_W'(1);
        end
      end else begin
        idleCount_r <= '0;
      end
    end
  end

  // Tolerance band from the running sum; the upper bound saturates at full scale.
  assign avg_s       = WIDTH'(sum_r >> DEPTH_LOG2);
  assign tol_s       = avg_s >> TOL_SHIFT;
  assign upperSum_s  = {1'b0, avg_s} + {1'b0, tol_s};
  assign upperNext_s = upperSum_s[WIDTH] ? {WIDTH{1'b1}} : upperSum_s[WIDTH-1:0];
  assign lowerNext_s = avg_s - tol_s;

  // The entry being overwritten only leaves the sum once the buffer has filled.
  assign oldEntry_s  = (fillCount_r == FILL_W'(DEPTH)) ? history_r[wrPtr_r] : '0;
  assign inBounds_s  = (shiftReg_r >= lowerBound_r) && (shiftReg_r <= upperBound_r);
  assign streakInc_s = rejectStreak_r + 8'd1;
  assign fillInc_s   = fillCount_r + FILL_W'(1);
  assign wrIdx_s     = rebaseline_s ? '0 : wrPtr_r;

  // Filter state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= FILL;
    end else begin
      state_r <= stateNext_s;
    end
  end

  // Accept/reject/rebaseline decision and next filter state.
  always_comb begin
    stateNext_s  = state_r;
    accept_s     = 1'b0;
    reject_s     = 1'b0;
    rebaseline_s = 1'b0;
    if (sampleValid_r) begin
      case (state_r)
        FILL: begin
          accept_s = 1'b1;
          if (fillInc_s == FILL_W'(DEPTH)) begin
            stateNext_s = TRACK;
          end else begin
            stateNext_s = FILL;
          end
        end
        TRACK: begin
          if (inBounds_s) begin
            accept_s = 1'b1;
          end else if (streakInc_s == 8'(MAX_REJECTS)) begin
            rebaseline_s = 1'b1;
            stateNext_s  = FILL;
          end else begin
            reject_s = 1'b1;
          end
        end
        default: stateNext_s = FILL;
      endcase
    end else begin
      stateNext_s = state_r;
    end
  end

  // History buffer; stale contents are masked by the fill count, so no reset is needed.
  always_ff @(posedge clk) begin
    if (accept_s || rebaseline_s) begin
      history_r[wrIdx_s] <= shiftReg_r;
    end
  end

  // Running sum, pointers, streak, bounds and the registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sum_r              <= '0;
      wrPtr_r            <= '0;
      fillCount_r        <= '0;
      upperBound_r       <= '0;
      lowerBound_r       <= '0;
      rejectStreak_r     <= 8'd0;
      temperature_r      <= '0;
      temperatureReady_r <= 1'b0;
      anomaly_r          <= 1'b0;
    end else begin
      temperatureReady_r <= accept_s | rebaseline_s;
      anomaly_r          <= reject_s;
      upperBound_r       <= upperNext_s;
      lowerBound_r       <= lowerNext_s;
      if (rebaseline_s) begin
        sum_r          <= SUM_W'(shiftReg_r);
        wrPtr_r        <= DEPTH_LOG2'(1);
        fillCount_r    <= FILL_W'(1);
        rejectStreak_r <= 8'd0;
        temperature_r  <= shiftReg_r;
      end else if (accept_s) begin
        sum_r          <= sum_r + SUM_W'(shiftReg_r) - SUM_W'(oldEntry_s);
        wrPtr_r        <= wrPtr_r + DEPTH_LOG2'(1);
        fillCount_r    <= (state_r == FILL) ? fillInc_s : fillCount_r;
        rejectStreak_r <= 8'd0;
        temperature_r  <= shiftReg_r;
      end else if (reject_s) begin
        rejectStreak_r <= streakInc_s;
      end
    end
  end

  assign temperatureReady = temperatureReady_r;
  assign anomaly          = anomaly_r;
  assign temperature      = temperature_r;
  assign rejectStreak     = rejectStreak_r;
  assign filterState      = state_r;

endmodule

// File: doc/temperature_anomaly_filter.md
TEMPERATURE_ANOMALY_FILTER -- requirements
Module: temperature_anomaly_filter

Interface
REQ-001 SHALL have parameter WIDTH, default 16: sample bit width; legal range 4..32.
REQ-002 SHALL have parameter DEPTH_LOG2, default 4: history depth is 2^DEPTH_LOG2 entries; legal range 1..6.
REQ-003 SHALL have parameter TOL_SHIFT, default 3: tolerance is avg >> TOL_SHIFT.
REQ-004 SHALL have parameter MAX_REJECTS, default 4: consecutive rejects that force a rebaseline; legal range 1..255.
REQ-005 SHALL have parameter TIMEOUT, default 1024: idle clk cycles after which a partial frame is discarded.
REQ-006 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-007 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-008 SHALL have port sda, input, 1: asynchronous serial data, MSB first.
REQ-009 SHALL have port scl, input, 1: asynchronous serial clock; sda is sampled on its rising edge.
REQ-010 SHALL have port temperatureReady, output, 1: one-cycle pulse, accepted sample.
REQ-011 SHALL have port temperature, output, WIDTH: last accepted sample; held between accepts.
REQ-012 SHALL have port anomaly, output, 1: one-cycle pulse, rejected sample.
REQ-013 SHALL have port rejectStreak, output, 8: current consecutive reject count.
REQ-014 SHALL have port filterState, output, 2: 0 = FILL, 1 = TRACK.

Function
REQ-015 SHALL pass scl and sda each through a 2-flop synchronizer; scl rise = sync_scl & ~sync_scl_d.
REQ-016 SHALL shift synchronized sda into a WIDTH-bit shift register on each scl rise and count rises; on the WIDTH-th rise it SHALL raise an internal sampleValid for exactly 1 cycle and clear the bit counter.
REQ-017 SHALL clear the bit counter and discard the partial frame when the bit counter is nonzero and TIMEOUT consecutive cycles pass with no scl rise; no output activity SHALL result.
REQ-018 SHALL store accepted samples in a circular buffer of 2^DEPTH_LOG2 entries; the write pointer SHALL wrap from 2^DEPTH_LOG2-1 to 0.
REQ-019 SHALL keep a running sum of WIDTH+DEPTH_LOG2 bits, updated on accept as sum + new - overwritten entry; the overwritten entry SHALL count as 0 while the buffer is not full.
REQ-020 SHALL compute avg = sum >> DEPTH_LOG2 and tol = avg >> TOL_SHIFT, and register upper = min(avg + tol, 2^WIDTH-1) and lower = avg - tol (which cannot underflow).
REQ-021 SHALL update bounds 2 cycles after an accept: sum at t+1, bounds at t+2.
REQ-022 In FILL, every sampleValid SHALL be accepted; a fill counter SHALL increment per accept; the FSM SHALL go to TRACK in the cycle the counter reaches 2^DEPTH_LOG2.
REQ-023 In TRACK, a sample SHALL be accepted iff lower <= sample <= upper, inclusive at both ends; otherwise it is rejected.
REQ-024 An accept SHALL clear rejectStreak; a reject SHALL increment rejectStreak and pulse anomaly at t+1.
REQ-025 A reject that would make rejectStreak equal MAX_REJECTS SHALL trigger a rebaseline instead, in the same cycle:
- clear sum, fill counter and write pointer
- store the current sample as entry 0, with sum = sample and fill count = 1
- clear rejectStreak and enter FILL
- treat the sample as accepted (temperatureReady pulse, no anomaly pulse)
REQ-026 SHALL register outputs so that a decision at sampleValid cycle t drives temperatureReady/anomaly at t+1; temperature SHALL update at t+1 on accept only.
REQ-027 temperatureReady and anomaly SHALL never be high in the same cycle.
REQ-028 End-to-end latency SHALL be 2 synchronizer cycles + 1 edge cycle + 1 output cycle, counted from the last scl rise at the pin.

Reset
REQ-029 Asserting reset SHALL immediately clear the following:
- temperatureReady, anomaly, temperature, rejectStreak
- sum, bounds, fill counter, write pointer, bit counter, shift register, timeout counter, synchronizers
- filterState, which goes to FILL
REQ-030 Buffer contents need not be cleared on reset; while the buffer is not full, its entries SHALL be excluded through the fill logic.
REQ-031 Reset mid-frame SHALL discard the partial frame; the first complete frame after deassertion SHALL be accepted in FILL.

Verification (WIDTH=16, DEPTH_LOG2=2, TOL_SHIFT=3, MAX_REJECTS=3)
REQ-032 Reset, then 4 frames of 800 -> 4 temperatureReady pulses, temperature=800, filterState=TRACK, upper=900, lower=700.
REQ-033 After REQ-032, frames 900 then 901:
- 900 SHALL be accepted (inclusive bound)
- bounds then become 825+103=928 and 722
- 901 SHALL be accepted
- a following frame of 2000 SHALL pulse anomaly, with rejectStreak=1 and temperature holding 901
REQ-034 In TRACK, three frames of 2000 -> anomaly twice (rejectStreak 1, 2); the third frame SHALL give temperatureReady with temperature=2000, filterState=FILL, rejectStreak=0 and fill count 1.
REQ-035 Send 10 bits, then hold scl idle for 2 + TIMEOUT cycles, then send a full frame of 0x0320 -> exactly one temperatureReady with temperature=800, and no other pulses.
REQ-036 Assert reset after 8 bits of a frame -> all outputs 0 and FILL; the next full frame 0x1234 SHALL be accepted with temperature=0x1234.
REQ-037 Fill with 4 frames of 0xFFF0 -> avg=0xFFF0, tol=0x1FFE, upper saturates to 0xFFFF, lower=0xDFF2; a frame of 0xFFFF SHALL be accepted.
